pattern_window_counter: RTL and testbench
=========================================

Name: pattern_window_counter

Overview:
- Downstream consumer of the serial sequence detector's y1 ("101" detected) and y2 ("0100" detected) outputs.
- Counts detection events on each line over a fixed window of WINDOW clock cycles.
- Presents both counts, with sticky saturation flags, through a valid/ready result handshake to the host/status logic.

Parameters:
WINDOW, 16, number of sample cycles per counting window (legal range >= 1)
CW, 8, width of each event counter

Ports:
ck  input  1  clock; all state updates on rising edge
rs  input  1  asynchronous, active-high reset
en  input  1  start/continue request; sampled only in IDLE and at result handshake
y1  input  1  "101" detection level from detector; one event per cycle sampled high
y2  input  1  "0100" detection level from detector; one event per cycle sampled high
cnt1  output  CW  y1 event count of last completed window
cnt2  output  CW  y2 event count of last completed window
ovf1  output  1  cnt1 saturated during that window
ovf2  output  1  cnt2 saturated during that window
out_valid  output  1  result registers hold a completed window
out_ready  input  1  consumer accepts result
busy  output  1  high while in COUNT

Behaviour:
- Reset (rs=1, asynchronous): state=IDLE; cnt1=cnt2=0; ovf1=ovf2=0; out_valid=0; busy=0; accumulators and window counter cleared. Reset mid-window discards the partial window with no out_valid.
- Detector outputs change on the falling edge of ck. This block samples on the rising edge, half a period later. Each detector pulse is one full period wide and is therefore sampled exactly once.
- States:
  - IDLE: rising edge with en=1 -> COUNT; accumulators and window counter cleared. en=0 -> stay.
  - COUNT: busy=1. Every rising edge samples y1 and y2.
    - acc1 += y1, saturating at 2^CW-1; ovf1 acc flag set sticky on any increment attempt at max. Same for acc2/y2.
    - y1 and y2 high in the same cycle both count, independently.
    - Window counter increments each sample. The edge taking the WINDOW-th sample also:
      - loads cnt1/cnt2/ovf1/ovf2 from the accumulators including that sample;
      - sets out_valid=1;
      - moves to HOLD.
    - en is ignored inside COUNT; deasserting it does not abort the window.
  - HOLD: busy=0, out_valid=1.
    - cnt/ovf outputs stable. y1/y2 ignored (events in IDLE/HOLD are not counted).
    - Rising edge with out_ready=1 completes the handshake, out_valid drops, then:
      - en=1 -> COUNT, accumulators cleared, zero idle cycles;
      - en=0 -> IDLE.
    - out_ready=0 -> hold indefinitely.
- Latency: en accepted at edge k -> samples at edges k+1..k+WINDOW -> out_valid high after edge k+WINDOW.
- Result registers keep their last values after the handshake until the next window completes. Only out_valid qualifies them.
- out_ready outside HOLD has no effect.
- Window counter width is clog2(WINDOW+1). WINDOW=1 is legal: one sample per window.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, COUNT=2'b01, HOLD=2'b10); a clog2 helper for sizing the window counter.
- One natural sub-module: pwc_sat_counter. It is a CW-bit saturating accumulator with synchronous clear, increment enable and sticky overflow, plus the asynchronous rs. It is instantiated twice, once for y1 and once for y2.
- Top level holds the FSM, window counter, result registers and handshake.

Test Plan:
- Reset: assert rs for 3 cycles mid-traffic -> out_valid=0, cnt1=cnt2=0, ovf1=ovf2=0, busy=0 immediately, before any clock edge.
- Basic window (WINDOW=16, CW=8): en=1 for one cycle; y1 pulses on samples 3, 7 and 11; y2 pulses on sample 9; out_ready=1 -> out_valid rises exactly 16 edges after en accepted with cnt1=3, cnt2=1, ovf=0; next cycle out_valid=0, state IDLE.
- Saturation (CW=3): y1 held high for all 16 samples, y2=0 -> cnt1=7, ovf1=1, cnt2=0, ovf2=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with y1/y2 pulsing during HOLD -> outputs unchanged, pulses not counted. Then out_ready=1 with en=1 -> COUNT on the next edge; following result counts only the new window's 2 injected y1 pulses (cnt1=2).
- Reset mid-window: rs pulse at sample 8 of a window containing 4 y1 events -> no out_valid. Fresh window after reset with 1 y1 event -> cnt1=1.
- Edge cases: WINDOW=1 with y1=y2=1 on the single sample -> cnt1=1, cnt2=1, out_valid 1 edge after en accepted. Back-to-back windows with en and out_ready held high -> out_valid high exactly one cycle per 17 cycles.

Source files
------------

// File: rtl/pattern_window_counter_pkg.sv
// pattern_window_counter_pkg: state encoding and window-counter sizing shared by the counter block.
package pattern_window_counter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pwc_sat_counter.sv
// pwc_sat_counter: saturating event accumulator with sticky overflow.
// Exposes its next value so the owner can capture a window total including the final sample.
module pwc_sat_counter #(
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rs,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] nxt_cnt,
    output logic          nxt_ovf
);
    logic [CW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          at_max;

    always_comb begin
        at_max = &acc_q;
        acc_d  = clr ? '0 : (inc && !at_max) ? acc_q + CW'(1) : acc_q;
        ovf_d  = clr ? 1'b0 : ovf_q | (inc & at_max);
    end

    assign nxt_cnt = acc_d;
    assign nxt_ovf = ovf_d;

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/pattern_window_counter.sv
// pattern_window_counter: counts y1/y2 detection events over WINDOW-cycle windows
// and presents the totals with saturation flags through a valid/ready handshake.
module pattern_window_counter
    import pattern_window_counter_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CW     = 8
) (
    input  logic          ck,
    input  logic          rs,
    input  logic          en,
    input  logic          y1,
    input  logic          y2,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic          ovf1,
    output logic          ovf2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);
    localparam int WW = clog2(WINDOW + 1);
    localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, nxt1, nxt2;
    logic          ovf1_q, ovf1_d, ovf2_q, ovf2_d, nov1, nov2;
    logic          sampling, done, start;

    pwc_sat_counter #(.CW(CW)) u_acc1 (
        .ck(ck), .rs(rs), .clr(start), .inc(sampling & y1), .nxt_cnt(nxt1), .nxt_ovf(nov1)
    );
    pwc_sat_counter #(.CW(CW)) u_acc2 (
        .ck(ck), .rs(rs), .clr(start), .inc(sampling & y2), .nxt_cnt(nxt2), .nxt_ovf(nov2)
    );

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            state_q <= IDLE;
            win_q   <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en ? COUNT : IDLE;
            COUNT:   state_d = done ? HOLD : COUNT;
            HOLD:    state_d = out_ready ? (en ? COUNT : IDLE) : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // A window starts from IDLE or straight out of an accepted result.
    always_comb begin
        sampling = state_q == COUNT;
        done     = sampling && win_q == LAST;
        start    = en && (state_q == IDLE || (state_q == HOLD && out_ready));
        win_d    = start ? '0 : sampling ? win_q + WW'(1) : win_q;
        cnt1_d   = done ? nxt1 : cnt1_q;
        cnt2_d   = done ? nxt2 : cnt2_q;
        ovf1_d   = done ? nov1 : ovf1_q;
        ovf2_d   = done ? nov2 : ovf2_q;
    end

    always_comb begin
        busy      = state_q == COUNT;
        out_valid = state_q == HOLD;
        cnt1      = cnt1_q;
        cnt2      = cnt2_q;
        ovf1      = ovf1_q;
        ovf2      = ovf2_q;
    end
endmodule

// File: tb/tb_pattern_window_counter.sv
// tb_pattern_window_counter: scoreboard bench over three configurations
// (16/8, 16/3 and 1/8) sharing one stimulus bus; sel picks the one being observed.
module tb_pattern_window_counter;
    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        logic       o1;
        logic       o2;
        int         ec;
    } res_t;

    logic ck = 0, rs = 0, en = 0, y1 = 0, y2 = 0, out_ready = 1;
    logic [7:0] a_c1, a_c2, c_c1, c_c2, m_c1, m_c2;
    logic [2:0] b_c1, b_c2;
    logic a_o1, a_o2, a_v, a_b, b_o1, b_o2, b_v, b_b, c_o1, c_o2, c_v, c_b;
    logic m_o1, m_o2, m_v, m_b, pv = 0;
    int checks = 0, errors = 0, cyc = 0, sel = 0, vcount;
    res_t sb[$];

    always #5 ck = ~ck;
    always @(posedge ck) cyc++;

    pattern_window_counter #(.WINDOW(16), .CW(8)) u_a (
        .ck(ck), .rs(rs), .en(en), .y1(y1), .y2(y2), .cnt1(a_c1), .cnt2(a_c2),
        .ovf1(a_o1), .ovf2(a_o2), .out_valid(a_v), .out_ready(out_ready), .busy(a_b)
    );
    pattern_window_counter #(.WINDOW(16), .CW(3)) u_b (
        .ck(ck), .rs(rs), .en(en), .y1(y1), .y2(y2), .cnt1(b_c1), .cnt2(b_c2),
        .ovf1(b_o1), .ovf2(b_o2), .out_valid(b_v), .out_ready(out_ready), .busy(b_b)
    );
    pattern_window_counter #(.WINDOW(1), .CW(8)) u_c (
        .ck(ck), .rs(rs), .en(en), .y1(y1), .y2(y2), .cnt1(c_c1), .cnt2(c_c2),
        .ovf1(c_o1), .ovf2(c_o2), .out_valid(c_v), .out_ready(out_ready), .busy(c_b)
    );

    always_comb begin
        m_c1 = sel == 0 ? a_c1 : sel == 1 ? {5'd0, b_c1} : c_c1;
        m_c2 = sel == 0 ? a_c2 : sel == 1 ? {5'd0, b_c2} : c_c2;
        m_o1 = sel == 0 ? a_o1 : sel == 1 ? b_o1 : c_o1;
        m_o2 = sel == 0 ? a_o2 : sel == 1 ? b_o2 : c_o2;
        m_v  = sel == 0 ? a_v : sel == 1 ? b_v : c_v;
        m_b  = sel == 0 ? a_b : sel == 1 ? b_b : c_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] p1, input logic [15:0] p2,
                                   input int w, input int cw, input int ec);
        res_t r;
        int n1, n2, mx;
        n1 = 0;
        n2 = 0;
        mx = (1 << cw) - 1;
        for (int i = 0; i < w; i++) begin
            n1 += int'(p1[i]);
            n2 += int'(p2[i]);
        end
        r.c1 = 8'(n1 > mx ? mx : n1);
        r.c2 = 8'(n2 > mx ? mx : n2);
        r.o1 = n1 > mx;
        r.o2 = n2 > mx;
        r.ec = ec;
        return r;
    endfunction

    // Compare each freshly completed result against the oldest expectation.
    always @(posedge ck) begin
        res_t r;
        #1;
        if (m_v && !pv) begin
            if (sb.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                r = sb.pop_front();
                chk("cnt1", m_c1, r.c1);
                chk("cnt2", m_c2, r.c2);
                chk("ovf1", m_o1, r.o1);
                chk("ovf2", m_o2, r.o2);
                chk("latency", cyc, r.ec);
            end
        end
        pv = m_v;
    end

    task automatic do_reset(input int n);
        @(negedge ck);
        rs = 1; en = 0; y1 = 0; y2 = 0;
        repeat (n) @(negedge ck);
        rs = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, m_v, 0);
        chk({tag, "_busy"}, m_b, 0);
        chk({tag, "_cnt1"}, m_c1, 0);
        chk({tag, "_cnt2"}, m_c2, 0);
        chk({tag, "_ovf1"}, m_o1, 0);
        chk({tag, "_ovf2"}, m_o2, 0);
    endtask

    // Caller raises en at a falling edge; this drives w samples and expects one result.
    task automatic window(input int w, input int cw, input logic [15:0] p1, input logic [15:0] p2);
        sb.push_back(model(p1, p2, w, cw, cyc + 1 + w));
        @(negedge ck);
        en = 0;
        chk("busy_after_start", m_b, 1);
        for (int i = 0; i < w; i++) begin
            y1 = p1[i];
            y2 = p2[i];
            @(negedge ck);
        end
        y1 = 0;
        y2 = 0;
        chk("result_seen", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        #1 rs = 1;
        #1 check_reset_vals("por");
        repeat (2) @(negedge ck);
        rs = 0;

        @(negedge ck); en = 1;
        window(16, 8, 16'h0444, 16'h0100);
        @(negedge ck);
        chk("basic_valid_drop", m_v, 0);
        chk("basic_idle_busy", m_b, 0);

        @(negedge ck); en = 1;
        @(negedge ck); en = 0;
        for (int i = 0; i < 7; i++) begin
            y1 = (i % 2 == 0);
            @(negedge ck);
        end
        y1 = 0;
        @(posedge ck);
        #2 rs = 1;
        #1 check_reset_vals("async_rst");
        repeat (3) @(negedge ck);
        rs = 0;
        repeat (20) @(negedge ck);
        chk("no_valid_after_rst", m_v, 0);
        @(negedge ck); en = 1;
        window(16, 8, 16'h0020, 16'h0000);

        do_reset(2);
        sel = 1;
        @(negedge ck); en = 1;
        window(16, 3, 16'hFFFF, 16'h0000);

        do_reset(2);
        sel = 0;
        out_ready = 0;
        @(negedge ck); en = 1;
        window(16, 8, 16'h0101, 16'h8000);
        for (int i = 0; i < 5; i++) begin
            y1 = (i % 2 == 0);
            y2 = (i % 2 == 1);
            @(negedge ck);
            chk("hold_valid", m_v, 1);
            chk("hold_cnt1", m_c1, 2);
            chk("hold_cnt2", m_c2, 1);
        end
        y1 = 1; y2 = 1; out_ready = 1; en = 1;
        window(16, 8, 16'h0410, 16'h0000);

        do_reset(2);
        sel = 2;
        @(negedge ck); en = 1;
        window(1, 8, 16'h0001, 16'h0001);

        do_reset(2);
        sel = 0;
        @(negedge ck); en = 1; y1 = 1; y2 = 0;
        for (int n = 0; n < 3; n++) sb.push_back(model(16'hFFFF, 16'h0000, 16, 8, cyc + 17 + 17 * n));
        vcount = 0;
        for (int i = 1; i <= 51; i++) begin
            @(negedge ck);
            vcount += int'(m_v);
        end
        en = 0; y1 = 0;
        @(negedge ck);
        chk("b2b_valid_cycles", vcount, 3);
        chk("b2b_drain", sb.size(), 0);
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
